// File: rtl/stream_xbar_router.sv
// stream_xbar_router: N_INPUTS x N_OUTPUTS val/rdy stream crossbar with a
// registered routing configuration, 2-entry output FIFOs, broadcast support
// and drain-before-reconfigure behaviour.
// Optional feature macro: XBAR_MSG_COUNT_EN (per-output delivered-message
// counters; when undefined msg_count is tied to zero).
module stream_xbar_router #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned N_INPUTS  = 2,
   parameter int unsigned N_OUTPUTS = 2,
   parameter int unsigned SEL_W     = 1,
   parameter int unsigned CFG_W     = N_OUTPUTS * (SEL_W + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_INPUTS*BIT_WIDTH-1:0]  recv_msg,
   input  logic [N_INPUTS-1:0]            recv_val,
   output logic [N_INPUTS-1:0]            recv_rdy,
   output logic [N_OUTPUTS*BIT_WIDTH-1:0] send_msg,
   output logic [N_OUTPUTS-1:0]           send_val,
   input  logic [N_OUTPUTS-1:0]           send_rdy,
   input  logic [CFG_W-1:0]               control,
   input  logic                           control_val,
   output logic                           control_rdy,
   output logic [CFG_W-1:0]               cfg_o,
   output logic [N_OUTPUTS*16-1:0]        msg_count
);

   localparam int unsigned FW = SEL_W + 1;
   // Output 0 enabled selecting input 0, all other outputs disabled.
   localparam logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(1) << SEL_W;

   logic [CFG_W-1:0]     cfg_q;
   logic [N_OUTPUTS-1:0] active;
   logic [SEL_W-1:0]     sel [N_OUTPUTS];
   logic [N_OUTPUTS-1:0] enq;
   logic [N_OUTPUTS-1:0] deq;
   logic [BIT_WIDTH-1:0] enq_data [N_OUTPUTS];
   logic [BIT_WIDTH-1:0] mem [N_OUTPUTS][2];
   logic [N_OUTPUTS-1:0] wr_ptr;
   logic [N_OUTPUTS-1:0] rd_ptr;
   logic [1:0]           count [N_OUTPUTS];
   logic                 cfg_load;
   logic                 any_sel;
   logic                 all_room;

   // Decode per-output enable/select; out-of-range selects count as disabled.
   always_comb begin
      for (int j = 0; j < int'(N_OUTPUTS); j++) begin
         sel[j]    = cfg_q[j*FW +: SEL_W];
         active[j] = cfg_q[j*FW + SEL_W] && (32'(sel[j]) < 32'(N_INPUTS));
      end
   end

   // Input ready: selected by some active output and every such FIFO has room.
   always_comb begin
      recv_rdy = '0;
      any_sel  = 1'b0;
      all_room = 1'b1;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
         any_sel  = 1'b0;
         all_room = 1'b1;
         for (int j = 0; j < int'(N_OUTPUTS); j++) begin
            if (active[j] && (sel[j] == SEL_W'(i))) begin
               any_sel = 1'b1;
               if (count[j] == 2'd2) all_room = 1'b0;
            end
         end
         recv_rdy[i] = reset && !control_val && any_sel && all_room;
      end
   end

   // Route accepted input data to every active output that selects it.
   always_comb begin
      enq = '0;
      deq = '0;
      for (int j = 0; j < int'(N_OUTPUTS); j++) begin
         enq_data[j] = '0;
         for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (active[j] && (sel[j] == SEL_W'(i))) begin
               enq[j]      = recv_val[i] && recv_rdy[i];
               enq_data[j] = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
            end
         end
         deq[j] = (count[j] != 2'd0) && send_rdy[j];
      end
   end

   // Output side view of the FIFOs and drain detection for reconfiguration.
   always_comb begin
      control_rdy = 1'b1;
      for (int j = 0; j < int'(N_OUTPUTS); j++) begin
         send_val[j]                         = (count[j] != 2'd0);
         send_msg[j*BIT_WIDTH +: BIT_WIDTH]  = mem[j][rd_ptr[j]];
         if (count[j] != 2'd0) control_rdy = 1'b0;
      end
      cfg_load = control_val && control_rdy;
      cfg_o    = cfg_q;
   end

   // Per-output 2-entry FIFOs; simultaneous enq/deq keeps the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < int'(N_OUTPUTS); j++) begin
            count[j]  <= 2'd0;
            wr_ptr[j] <= 1'b0;
            rd_ptr[j] <= 1'b0;
            mem[j][0] <= '0;
            mem[j][1] <= '0;
         end
      end else begin
         for (int j = 0; j < int'(N_OUTPUTS); j++) begin
            if (enq[j]) begin
               mem[j][wr_ptr[j]] <= enq_data[j];
               wr_ptr[j]         <= ~wr_ptr[j];
            end
            if (deq[j]) rd_ptr[j] <= ~rd_ptr[j];
            case ({enq[j], deq[j]})
               2'b10:   count[j] <= count[j] + 2'd1;
               2'b01:   count[j] <= count[j] - 2'd1;
               default: count[j] <= count[j];
            endcase
         end
      end
   end

   // Routing configuration register, loaded only once all FIFOs are empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cfg_q <= CFG_DEFAULT;
      else if (cfg_load) cfg_q <= control;
   end

`ifdef XBAR_MSG_COUNT_EN
   logic [15:0] cnt [N_OUTPUTS];

   // Saturating delivered-message counters, cleared on reconfiguration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < int'(N_OUTPUTS); j++) cnt[j] <= 16'd0;
      end else begin
         for (int j = 0; j < int'(N_OUTPUTS); j++) begin
            if (cfg_load) cnt[j] <= 16'd0;
            else if (deq[j] && (cnt[j] != 16'hFFFF)) cnt[j] <= cnt[j] + 16'd1;
         end
      end
   end

   // Flatten counters onto the output bus.
   always_comb begin
      for (int j = 0; j < int'(N_OUTPUTS); j++) msg_count[j*16 +: 16] = cnt[j];
   end
`else
   assign msg_count = '0;
`endif

endmodule

// File: tb/tb_stream_xbar_router.sv
// Self-checking bench for stream_xbar_router: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_stream_xbar_router;

   localparam int BW = 32;
   localparam int NI = 2;
   localparam int NO = 2;
   localparam int SW = 1;
   localparam int CW = NO * (SW + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic [NI*BW-1:0] recv_msg;
   logic [NI-1:0]    recv_val;
   logic [NI-1:0]    recv_rdy;
   logic [NO*BW-1:0] send_msg;
   logic [NO-1:0]    send_val;
   logic [NO-1:0]    send_rdy;
   logic [CW-1:0]    control;
   logic             control_val;
   logic             control_rdy;
   logic [CW-1:0]    cfg_o;
   logic [NO*16-1:0] msg_count;

   always #5 clk = ~clk;

   stream_xbar_router #(
      .BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO), .SEL_W(SW)
   ) dut (
      .clk(clk), .reset(reset),
      .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
      .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
      .control(control), .control_val(control_val), .control_rdy(control_rdy),
      .cfg_o(cfg_o), .msg_count(msg_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per output plus the routing table.
   logic [BW-1:0] mq [NO][$];
   bit            m_en  [NO];
   int            m_sel [NO];
   int            mcnt  [NO];

   function automatic void model_reset();
      for (int j = 0; j < NO; j++) begin
         mq[j].delete();
         m_en[j]  = (j == 0);
         m_sel[j] = 0;
         mcnt[j]  = 0;
      end
   endfunction

   function automatic bit m_active(input int j);
      return m_en[j] && (m_sel[j] < NI);
   endfunction

   function automatic bit m_rdy(input int i);
      bit any = 1'b0;
      if (!reset || control_val) return 1'b0;
      for (int j = 0; j < NO; j++) begin
         if (m_active(j) && m_sel[j] == i) begin
            any = 1'b1;
            if (mq[j].size() >= 2) return 1'b0;
         end
      end
      return any;
   endfunction

   function automatic bit m_idle();
      for (int j = 0; j < NO; j++) if (mq[j].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Advance the model on each rising edge from the inputs seen at that edge.
   always @(posedge clk) begin
      bit acc [NI];
      bit dq  [NO];
      bit ld;
      if (reset) begin
         for (int i = 0; i < NI; i++) acc[i] = recv_val[i] && m_rdy(i);
         for (int j = 0; j < NO; j++) dq[j] = (mq[j].size() != 0) && send_rdy[j];
         ld = control_val && m_idle();
         for (int j = 0; j < NO; j++) begin
            if (dq[j]) begin
               void'(mq[j].pop_front());
               if (mcnt[j] < 65535) mcnt[j]++;
            end
            if (m_active(j) && acc[m_sel[j]])
               mq[j].push_back(recv_msg[m_sel[j]*BW +: BW]);
         end
         if (ld) begin
            for (int j = 0; j < NO; j++) begin
               m_en[j]  = control[j*(SW+1) + SW];
               m_sel[j] = int'(control[j*(SW+1) +: SW]);
               mcnt[j]  = 0;
            end
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      logic [NO-1:0] sv;
      logic [NI-1:0] rr;
      logic [CW-1:0] cf;
      for (int j = 0; j < NO; j++) begin
         sv[j]                = (mq[j].size() != 0);
         cf[j*(SW+1) + SW]    = m_en[j];
         cf[j*(SW+1) +: SW]   = SW'(m_sel[j]);
      end
      for (int i = 0; i < NI; i++) rr[i] = m_rdy(i);
      chk("send_val", 64'(send_val), 64'(sv));
      chk("recv_rdy", 64'(recv_rdy), 64'(rr));
      chk("control_rdy", 64'(control_rdy), 64'(m_idle()));
      chk("cfg_o", 64'(cfg_o), 64'(cf));
      for (int j = 0; j < NO; j++) begin
         if (mq[j].size() != 0) chk("send_msg", 64'(send_msg[j*BW +: BW]), 64'(mq[j][0]));
`ifdef XBAR_MSG_COUNT_EN
         chk("msg_count", 64'(msg_count[j*16 +: 16]), 64'(mcnt[j]));
`endif
      end
`ifndef XBAR_MSG_COUNT_EN
      chk("msg_count_zero", 64'(msg_count), 64'd0);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word on input i and hold it until it is accepted.
   task automatic push(input int i, input logic [BW-1:0] d);
      bit done = 1'b0;
      recv_msg[i*BW +: BW] = d;
      recv_val[i]          = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         #1;
         done = recv_rdy[i];
         tick();
      end
      recv_val[i] = 1'b0;
      if (!done) chk("push_timeout", 64'd0, 64'd1);
   endtask

   // Request a configuration and hold it until it is accepted.
   task automatic load_cfg(input logic [CW-1:0] c);
      bit done = 1'b0;
      control     = c;
      control_val = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         #1;
         done = control_rdy;
         tick();
      end
      control_val = 1'b0;
      if (!done) chk("cfg_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      reset       = 1'b0;
      recv_msg    = '0;
      recv_val    = '0;
      send_rdy    = '0;
      control     = '0;
      control_val = 1'b0;
      model_reset();
      repeat (3) tick();

      // Reset state and default routing
      chk("rst_cfg", 64'(cfg_o), 64'h2);
      chk("rst_control_rdy", 64'(control_rdy), 64'd1);
      chk("rst_send_val", 64'(send_val), 64'd0);
      recv_msg = {32'h0000_000B, 32'h0000_000A};
      recv_val = 2'b11;
      send_rdy = 2'b11;
      #1;
      chk("rst_recv_rdy", 64'(recv_rdy), 64'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("dflt_recv_rdy", 64'(recv_rdy), 64'h1);
      tick();
      recv_val = 2'b00;
      #1;
      chk("dflt_send_val", 64'(send_val), 64'h1);
      chk("dflt_send_msg0", 64'(send_msg[31:0]), 64'hA);
      tick();
      tick();

      // Swap routing: out1 <- in0, out0 <- in1
      control     = 4'b1011;
      control_val = 1'b1;
      #1;
      chk("swap_control_rdy", 64'(control_rdy), 64'd1);
      tick();
      control_val = 1'b0;
      chk("swap_cfg", 64'(cfg_o), 64'hB);
      recv_msg = {32'h22, 32'h11};
      recv_val = 2'b11;
      #1;
      chk("swap_recv_rdy", 64'(recv_rdy), 64'h3);
      tick();
      recv_val = 2'b00;
      #1;
      chk("swap_send_val", 64'(send_val), 64'h3);
      chk("swap_out1", 64'(send_msg[63:32]), 64'h11);
      chk("swap_out0", 64'(send_msg[31:0]), 64'h22);
      tick();
      tick();

      // Broadcast input 0 with output 1 stalled
      load_cfg(4'b1010);
      send_rdy = 2'b01;
      push(0, 32'h1);
      push(0, 32'h2);
      chk("bc_stall_rdy", 64'(recv_rdy), 64'd0);
      recv_msg[31:0] = 32'h3;
      recv_val[0]    = 1'b1;
      tick();
      tick();
      #1;
      chk("bc_stall_rdy2", 64'(recv_rdy), 64'd0);
      chk("bc_stall_val", 64'(send_val), 64'h2);
      send_rdy = 2'b11;
      push(0, 32'h3);
      repeat (3) tick();
      chk("bc_drained", 64'(send_val), 64'd0);

      // Reconfigure while data is queued
      send_rdy = 2'b00;
      push(0, 32'hA);
      push(0, 32'hB);
      recv_msg[31:0] = 32'hC;
      recv_val[0]    = 1'b1;
      control        = 4'b1011;
      control_val    = 1'b1;
      #1;
      chk("rc_recv_rdy", 64'(recv_rdy), 64'd0);
      chk("rc_control_rdy", 64'(control_rdy), 64'd0);
      tick();
      tick();
      send_rdy = 2'b11;
      begin
         bit done = 1'b0;
         for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = control_rdy;
            tick();
         end
         if (!done) chk("rc_timeout", 64'd0, 64'd1);
      end
      control_val = 1'b0;
      recv_val    = 2'b00;
      chk("rc_cfg", 64'(cfg_o), 64'hB);
      chk("rc_empty", 64'(send_val), 64'd0);

      // Asynchronous reset with both FIFOs holding data
      send_rdy = 2'b00;
      push(0, 32'h5);
      push(1, 32'h6);
      recv_msg = {32'h8, 32'h7};
      recv_val = 2'b11;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("arst_send_val", 64'(send_val), 64'd0);
      chk("arst_recv_rdy", 64'(recv_rdy), 64'd0);
      chk("arst_cfg", 64'(cfg_o), 64'h2);
      recv_val = 2'b00;
      tick();
      reset    = 1'b1;
      send_rdy = 2'b11;
      push(0, 32'h77);
      tick();
      tick();

`ifdef XBAR_MSG_COUNT_EN
      // Delivered-message counter: count, saturate, clear on reconfiguration
      load_cfg(4'b0010);
      for (int k = 0; k < 5; k++) push(0, 32'(k + 100));
      tick();
      tick();
      chk("cnt_5", 64'(msg_count[15:0]), 64'd5);
      recv_msg[31:0] = 32'h5A;
      recv_val[0]    = 1'b1;
      repeat (70000) tick();
      recv_val[0] = 1'b0;
      tick();
      tick();
      chk("cnt_sat", 64'(msg_count[15:0]), 64'hFFFF);
      load_cfg(4'b0010);
      chk("cnt_clr", 64'(msg_count[15:0]), 64'd0);
`endif

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_xbar_router.md
Name: stream_xbar_router

Overview:
- Parametrised N_INPUTS x N_OUTPUTS val/rdy stream crossbar. Successor to the fixed one-in / one-out crossbar pair that sits between the Wishbone adapter and the compute blocks.
- Holds a registered routing configuration loaded through a control handshake. Each output has a 2-entry output FIFO.
- Supports broadcast: one input can drive several outputs at once.
- Reconfiguration waits until all in-flight data has drained.

Parameters:
- BIT_WIDTH, 32, message width.
- N_INPUTS, 2, number of input streams (>=1).
- N_OUTPUTS, 2, number of output streams (>=1).
- SEL_W, 1, width of each per-output input select. Must satisfy 2**SEL_W >= N_INPUTS.
- CFG_W, N_OUTPUTS*(SEL_W+1), configuration word width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- recv_msg  in  N_INPUTS*BIT_WIDTH  input messages; input i occupies [i*BIT_WIDTH +: BIT_WIDTH].
- recv_val  in  N_INPUTS  per-input valid.
- recv_rdy  out  N_INPUTS  per-input ready.
- send_msg  out  N_OUTPUTS*BIT_WIDTH  output messages; output j occupies [j*BIT_WIDTH +: BIT_WIDTH].
- send_val  out  N_OUTPUTS  per-output valid.
- send_rdy  in  N_OUTPUTS  per-output ready.
- control  in  CFG_W  new configuration.
  - Field j is [j*(SEL_W+1) +: SEL_W+1].
  - Bit SEL_W of field j is the enable; bits SEL_W-1:0 are the input select.
- control_val  in  1  configuration valid.
- control_rdy  out  1  configuration ready.
- cfg_o  out  CFG_W  currently active configuration.
- msg_count  out  N_OUTPUTS*16  per-output delivered-message counters (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFOs empty; send_val=0; recv_rdy=0.
  - Configuration = output 0 enabled selecting input 0; all other outputs disabled. cfg_o reflects this.
  - control_rdy=1; msg_count=0.
- Output j is active iff its enable=1 and its select < N_INPUTS. A select >= N_INPUTS is treated as disabled.
- recv_rdy[i] is combinational and equals 1 only when all of the following hold:
  - control_val=0;
  - at least one active output selects input i;
  - every active output selecting input i has FIFO count < 2.
  - Otherwise recv_rdy[i]=0. Unselected inputs are never ready.
- Transfer:
  - recv_val[i] && recv_rdy[i] enqueues recv_msg[i] into the FIFO of every active output selecting i, on the same edge (atomic broadcast).
  - Readiness is based on count < 2 only. A same-cycle dequeue is not considered.
- Output side:
  - send_val[j] = FIFO j non-empty; send_msg[j] = FIFO j head.
  - Dequeue on send_val[j] && send_rdy[j].
  - An enqueue and dequeue in the same cycle on the same FIFO keeps its count unchanged and preserves order.
- Latency: 1 cycle from input handshake to send_val. Throughput: 1 msg/cycle per output when send_rdy is held high.
- FIFO pointers: 1-bit read/write pointers plus a 2-bit count. Wrap-around is natural.
- Control:
  - control_rdy = all output FIFOs empty.
  - control_val && control_rdy loads control into the configuration register at that edge. The new routing applies from the next cycle.
  - While control_val=1, all recv_rdy are held at 0 so in-flight data drains and reconfiguration cannot starve.
  - Data already queued always leaves on the output it was routed to.
- No message is dropped or duplicated per output. A disabled output whose FIFO holds data still drains it.
- Simultaneous inputs: inputs routed to disjoint outputs proceed independently in the same cycle. If two outputs both select input i, one stalled output stalls input i for both.

Optional Feature:
- Macro: XBAR_MSG_COUNT_EN.
- Defined: msg_count[j] is a 16-bit counter.
  - Increments on each send handshake of output j.
  - Saturates at 0xFFFF.
  - Clears on reset and when a new configuration is accepted.
- Undefined: no counter registers are built; msg_count is tied to 0.

Test Plan:
- Reset/default:
  - Stimulus: pulse reset low; drive recv_val=2'b11, recv_msg={B,A}, send_rdy=2'b11.
  - Response: recv_rdy=2'b01; send_msg[0] = A one cycle later; send_val[1] stays 0; cfg_o = 4'b0010 (output 1 disabled, output 0 enabled selecting input 0).
- Swap routing:
  - Stimulus: control = {1,0, 1,1} (output 1 <- input 0, output 0 <- input 1) with FIFOs empty.
  - Response: control_rdy=1 and the configuration loads. Next cycle, input 0 data 0x11 appears on output 1 and input 1 data 0x22 appears on output 0, each 1 cycle after its handshake.
- Broadcast with backpressure:
  - Stimulus: both outputs select input 0; send_rdy=2'b01; stream 0x1, 0x2, 0x3.
  - Response: recv_rdy[0] drops after 2 accepts (FIFO 1 full). Output 0 receives only 0x1, 0x2 until send_rdy[1] rises. Then both outputs deliver 0x1, 0x2, 0x3 in order.
- Reconfigure during traffic:
  - Stimulus: raise control_val while FIFO 0 holds 2 entries and send_rdy=0.
  - Response: recv_rdy=0 and control_rdy=0. Release send_rdy; after 2 dequeues control_rdy=1 and the configuration loads. No data is lost or misrouted.
- Asynchronous reset mid-stream:
  - Stimulus: assert reset between clock edges with both FIFOs partially full.
  - Response: send_val=0 and recv_rdy=0 immediately; configuration returns to default.
- XBAR_MSG_COUNT_EN:
  - Stimulus: 5 deliveries on output 0.
  - Response: msg_count[15:0]=5. After 70000 further deliveries it reads 0xFFFF. After a configuration load it reads 0.
